crc_serial_checker: RTL
=======================

# crc_serial_checker

Receive-side companion of the serial CRC generator. It consumes a bit-serial frame: data bits qualified by `active`, then WIDTH CRC bits qualified by `valid`. It recomputes the CRC over the data bits and compares it bit-by-bit with the received CRC. One `done` pulse per frame reports match/mismatch and protocol errors to the downstream controller.

## Interface
- `WIDTH`, 8, CRC length in bits; also the number of CRC bits expected in the `valid` phase
- `POLY`, 8'h44, feedback tap mask, bits [WIDTH-2:0] used
- `SEED`, 8'hD8, LFSR value at reset and at the start of every frame
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `ser_in`  in  1  serial bit, LSB first for both data and CRC
- `active`  in  1  high while `ser_in` carries data bits
- `valid`  in  1  high while `ser_in` carries CRC bits
- `done`  out  1  one-cycle pulse at end of frame
- `crc_ok`  out  1  1 = received CRC equals computed; updated with `done`, held until next `done`
- `proto_err`  out  1  pulse with `done` when the frame was malformed
- `busy`  out  1  high in states DATA and CRC

## Operation
- LFSR step per data bit: `fb = ser_in ^ lfsr[0]`; `next[WIDTH-1] = fb`; for i < WIDTH-1, `next[i] = lfsr[i+1] ^ (POLY[i] & fb)`.
- States:
  - IDLE: `lfsr = SEED`. `active` -> DATA, consuming that bit. `valid` alone -> DONE with `proto_err`.
  - DATA: `active` = 1 steps the LFSR. `active` = 0 and `valid` = 0 holds, gap allowed. `valid` = 1 -> CRC, consuming that bit as CRC bit 0.
  - CRC: each `valid` cycle compares `ser_in` with `lfsr[0]`, then shifts `lfsr >> 1`, sets the sticky `mismatch` on inequality, and increments `bitcnt`.
    - After bit WIDTH-1 -> DONE.
    - `valid` dropping early -> DONE with short-frame error.
    - `active` seen in CRC -> DONE with `proto_err`.
  - DONE: one cycle. Drives `done` = 1, `crc_ok = ~mismatch & ~err`, `proto_err = err`. Reloads SEED, clears `mismatch`/`bitcnt`/`err`. Returns to IDLE.
- `active` and `valid` both high, in any state: protocol error, frame aborted through DONE.
- `valid` held longer than WIDTH cycles: the extra bits are ignored. The block waits in IDLE for `valid` low, and these bits raise no second error.
- `bitcnt` width is `$clog2(WIDTH+1)`. It never wraps within a frame.

## Timing
- Reset values: `done` = 0, `crc_ok` = 0, `proto_err` = 0, `busy` = 0, state IDLE, `lfsr` = SEED, counters 0. Reset mid-frame discards the frame and produces no `done`.
- Latency: `done` is asserted on the cycle after the last CRC bit is sampled, i.e. 1 cycle.
- Back-to-back: a new `active` may start on the cycle after `done`. `active` in the DONE cycle itself is a dropped bit, and the bench must not do that.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `CRC_CHK_ERRCNT_EN` defined: adds output `err_cnt` [7:0]. It increments on every `done` with `crc_ok` = 0, saturates at 8'hFF, and is reset to 0 by `rst` only.
- Without the macro: the port and the counter do not exist. All other behaviour is identical.

## Structure
- Package `crc_pkg`:
  - state enum {IDLE, DATA, CRC, DONE}
  - default WIDTH/POLY/SEED constants
  - `CRC_CNT_W` localparam function
- Sub-module `crc_lfsr` holds the step logic with `load`/`step`/`shift` controls. It is shared with the transmitter so both ends use the same equations.

## Test plan
- 1 data bit `ser_in` = 0, then CRC 8'h6C LSB first (0,0,1,1,0,1,1,0) -> `done` 1 cycle after the last bit, `crc_ok` = 1, `proto_err` = 0.
- 1 data bit `ser_in` = 1, then CRC 8'hA8 -> `crc_ok` = 1. Same frame with CRC 8'hA9 -> `crc_ok` = 0, `proto_err` = 0, `err_cnt` = 1 when enabled.
- 8-bit frame 8'hA5 with CRC from the reference model, 3 idle gap cycles between `active` and `valid`, then an immediate second identical frame -> two `done` pulses, both `crc_ok` = 1.
- `valid` for only 5 CRC bits -> `done` on the cycle after `valid` falls, `crc_ok` = 0, `proto_err` = 1.
- `active` and `valid` high together mid-frame -> abort, `proto_err` = 1. `rst` pulsed mid-CRC -> no `done`, all outputs 0, next frame checks correctly.
- 260 bad frames with `CRC_CHK_ERRCNT_EN` -> `err_cnt` saturates at 8'hFF.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared types and defaults for the serial CRC generator/checker pair.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2,
    DONE = 2'd3
  } crc_state_t;

  localparam int         CRC_WIDTH_DEF = 8;
  localparam logic [7:0] CRC_POLY_DEF  = 8'h44;
  localparam logic [7:0] CRC_SEED_DEF  = 8'hD8;

  // Bit counter width: must be able to hold WIDTH itself.
  function automatic int CRC_CNT_W(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/crc_lfsr.sv
// Serial CRC LFSR shared by transmitter and checker: load seed, step on a data bit,
// or shift out the remainder LSB first.
module crc_lfsr
  import crc_pkg::*;
#(
  parameter int               WIDTH = CRC_WIDTH_DEF,
  parameter logic [WIDTH-1:0] POLY  = CRC_POLY_DEF,
  parameter logic [WIDTH-1:0] SEED  = CRC_SEED_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic step,
  input  logic shift,
  input  logic ser_in,
  output logic lsb
);

  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] stepped;
  logic             fb;

  always_comb begin
    fb      = ser_in ^ lfsr[0];
    stepped = '0;
    stepped[WIDTH-1] = fb;
    for (int i = 0; i < WIDTH - 1; i++) begin
      stepped[i] = lfsr[i+1] ^ (POLY[i] & fb);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || load) begin
      lfsr <= SEED;
    end else if (step) begin
      lfsr <= stepped;
    end else if (shift) begin
      lfsr <= lfsr >> 1;
    end
  end

  assign lsb = lfsr[0];

endmodule

// File: rtl/crc_serial_checker.sv
// Bit-serial CRC receiver: recomputes the CRC over data bits and checks the received CRC.
// Optional CRC_CHK_ERRCNT_EN adds a saturating err_cnt of failed frames.
module crc_serial_checker
  import crc_pkg::*;
#(
  parameter int               WIDTH = CRC_WIDTH_DEF,
  parameter logic [WIDTH-1:0] POLY  = CRC_POLY_DEF,
  parameter logic [WIDTH-1:0] SEED  = CRC_SEED_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_in,
  input  logic       active,
  input  logic       valid,
  output logic       done,
  output logic       crc_ok,
  output logic       proto_err,
  output logic       busy
`ifdef CRC_CHK_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam int             CNT_W = CRC_CNT_W(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  crc_state_t       state;
  crc_state_t       state_n;
  logic [CNT_W-1:0] bitcnt;
  logic             mismatch;
  logic             err;
  logic             valid_hold;
  logic             lfsr_lsb;

  logic             take_crc;
  logic             step_data;
  logic             mismatch_n;
  logic             err_n;
  logic             to_done;
  logic             frame_ok;

  crc_lfsr #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load   (state == DONE),
    .step   (step_data),
    .shift  (take_crc),
    .ser_in (ser_in),
    .lsb    (lfsr_lsb)
  );

  always_comb begin
    state_n   = state;
    take_crc  = 1'b0;
    step_data = 1'b0;
    err_n     = err;
    case (state)
      IDLE: begin
        if (active && valid) begin
          state_n = DONE;
          err_n   = 1'b1;
        end else if (active) begin
          state_n   = DATA;
          step_data = 1'b1;
        end else if (valid && !valid_hold) begin
          state_n = DONE;
          err_n   = 1'b1;
        end
      end
      DATA: begin
        if (active && valid) begin
          state_n = DONE;
          err_n   = 1'b1;
        end else if (active) begin
          step_data = 1'b1;
        end else if (valid) begin
          take_crc = 1'b1;
          state_n  = (bitcnt == LAST) ? DONE : CRC;
        end
      end
      CRC: begin
        if (active) begin
          state_n = DONE;
          err_n   = 1'b1;
        end else if (valid) begin
          take_crc = 1'b1;
          state_n  = (bitcnt == LAST) ? DONE : CRC;
        end else begin
          // valid fell before all CRC bits arrived: short frame
          state_n = DONE;
          err_n   = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    mismatch_n = mismatch | (take_crc & (ser_in ^ lfsr_lsb));
    to_done    = (state_n == DONE);
    frame_ok   = ~mismatch_n & ~err_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bitcnt     <= '0;
      mismatch   <= 1'b0;
      err        <= 1'b0;
      valid_hold <= 1'b0;
      done       <= 1'b0;
      crc_ok     <= 1'b0;
      proto_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state     <= state_n;
      done      <= to_done;
      proto_err <= to_done & err_n;
      busy      <= (state_n == DATA) || (state_n == CRC);
      if (to_done) begin
        crc_ok <= frame_ok;
      end
      if (state == DONE) begin
        bitcnt     <= '0;
        mismatch   <= 1'b0;
        err        <= 1'b0;
        // CRC bits beyond WIDTH are swallowed until valid drops
        valid_hold <= valid;
      end else begin
        if (take_crc) begin
          bitcnt <= bitcnt + CNT_W'(1);
        end
        mismatch <= mismatch_n;
        err      <= err_n;
        if (!valid) begin
          valid_hold <= 1'b0;
        end
      end
    end
  end

`ifdef CRC_CHK_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'h00;
    end else if (to_done && !frame_ok && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'h01;
    end
  end
`endif

endmodule
